nbody_body_loader: RTL and testbench
====================================

NBODY_BODY_LOADER -- requirements
Module: nbody_body_loader

Interface
REQ-001 Parameter N, default 2: number of bodies loaded per run, range 1..400.
REQ-002 Parameter ADDR_W, default 15: body RAM address width.
REQ-003 Parameter DATA_W, default 80: body/force record width.
REQ-004 Parameter FORCE_BASE, default 400: first force-region address.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-007 start  input  1  begin a load run (sampled only in IDLE).
REQ-008 in_valid  input  1  in_data holds a body record.
REQ-009 in_data  input  DATA_W  body record.
REQ-010 in_ready  output  1  loader accepts in_data this cycle.
REQ-011 wr_en  output  1  RAM write strobe.
REQ-012 wr_addr  output  ADDR_W  RAM write address.
REQ-013 wr_data  output  DATA_W  RAM write data.
REQ-014 busy  output  1  run in progress (any state except IDLE).
REQ-015 done  output  1  one-cycle pulse at end of run.
REQ-016 count  output  ADDR_W  records written in current run.

Function
REQ-017 States: IDLE, LOAD, CLEAR, DONE; IDLE->LOAD on start=1.
REQ-018 LOAD: in_ready=1; a handshake is in_valid&in_ready in one cycle.
REQ-019 Each handshake k (k=0..N-1) drives wr_en=1, wr_addr=k, wr_data=in_data on the following cycle (1-cycle registered latency).
REQ-020 After handshake N-1, LOAD->CLEAR; in_ready drops in the same cycle the next state is entered.
REQ-021 CLEAR: writes wr_data=0 to FORCE_BASE+j, j=0..N-1, one per cycle, no backpressure; then CLEAR->DONE.
REQ-022 DONE: done=1 for exactly one cycle, then ->IDLE.
REQ-023 wr_en=0 in every cycle not listed in REQ-019/REQ-021; wr_addr/wr_data hold last values when wr_en=0.
REQ-024 count increments by 1 per wr_en pulse of LOAD, cleared on IDLE->LOAD; holds at N after run.
REQ-025 start while busy=1 is ignored; in_valid outside LOAD is ignored (no write, in_ready=0).
REQ-026 in_valid gaps in LOAD stall the run indefinitely with no writes.
REQ-027 start asserted in the DONE cycle is ignored; start in the following IDLE cycle begins a new run.
REQ-028 Address arithmetic is ADDR_W-bit unsigned; FORCE_BASE+N-1 must fit ADDR_W (elaboration-time assertion).

Reset
REQ-029 reset=0 forces IDLE immediately, regardless of clk.
REQ-030 Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, count=0.
REQ-031 Reset mid-run abandons the run; no further writes, no done pulse; RAM contents already written are not restored.

Configuration
REQ-032 Macro NBODY_LOADER_CLEAR_FORCES_EN defined: CLEAR state present as in REQ-021.
REQ-033 Macro undefined: CLEAR omitted; LOAD->DONE after final LOAD write, no force-region writes.

Structure
REQ-034 Package nbody_pkg holds DATA_W, ADDR_W, FORCE_BASE constants, body_t (DATA_W-bit) typedef and the loader state enum.
REQ-035 Single module; no sub-module.

Verification
REQ-036 N=2, start, bodies 0x1111..., 0x2222... back-to-back -> writes addr 0, 1 with those data, then 0 to 400, 401, done one cycle later, count=2.
REQ-037 in_valid low 5 cycles between records -> no writes during gap, same final RAM image, done delayed 5 cycles.
REQ-038 start pulsed during LOAD and at DONE -> ignored; exactly one done per legitimate start.
REQ-039 reset=0 after first handshake (N=2) -> outputs at reset values asynchronously, addr 1 never written, no done.
REQ-040 Macro undefined, N=3 -> writes to 0,1,2 only, done directly after addr 2 write, addrs 400..402 untouched.
REQ-041 After REQ-036, readback of addr 400 and 0 with 3-cycle read latency returns 0 and 0x1111... respectively.

Source files
------------

// File: rtl/nbody_pkg.sv
// rtl/nbody_pkg.sv - shared constants, record type and state encoding for the body loader
package nbody_pkg;

  localparam int NBODY_DATA_W     = 80;
  localparam int NBODY_ADDR_W     = 15;
  localparam int NBODY_FORCE_BASE = 400;

  typedef logic [NBODY_DATA_W-1:0] body_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_DONE
  } load_state_e;

endpackage

// File: rtl/nbody_body_loader.sv
// rtl/nbody_body_loader.sv - streams N body records into RAM, optionally zeroes the force region
// Optional force clearing is enabled by defining NBODY_LOADER_CLEAR_FORCES_EN.
module nbody_body_loader
  import nbody_pkg::*;
#(
  parameter int N          = 2,
  parameter int ADDR_W     = NBODY_ADDR_W,
  parameter int DATA_W     = NBODY_DATA_W,
  parameter int FORCE_BASE = NBODY_FORCE_BASE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] count
);

  if (N < 1 || N > 400 || (FORCE_BASE + N - 1) >= (1 << ADDR_W)) begin : g_param_check
    $error("nbody_body_loader: N or FORCE_BASE+N-1 out of range for ADDR_W");
  end

  localparam logic [ADDR_W-1:0] N_A = ADDR_W'(N);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  load_state_e state, state_nxt;
  logic        hs;

  assign hs = in_valid & in_ready;

`ifdef NBODY_LOADER_CLEAR_FORCES_EN
  localparam logic [ADDR_W-1:0] FB_A = ADDR_W'(FORCE_BASE);
  logic [ADDR_W-1:0] clr_idx;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_LOAD;
`ifdef NBODY_LOADER_CLEAR_FORCES_EN
      S_LOAD:  if (hs && count == N_A - ONE) state_nxt = S_CLEAR;
      S_CLEAR: if (clr_idx == N_A) state_nxt = S_DONE;
`else
      // Stay one extra cycle so done follows the final write rather than coinciding with it.
      S_LOAD: if (count == N_A) state_nxt = S_DONE;
`endif
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == S_LOAD) && (count != N_A);
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
  end

  // Write port is registered: a handshake in cycle t shows up on wr_* in cycle t+1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      count   <= '0;
`ifdef NBODY_LOADER_CLEAR_FORCES_EN
      clr_idx <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      if (state == S_IDLE && start) count <= '0;
      if (hs) begin
        wr_en   <= 1'b1;
        wr_addr <= count;
        wr_data <= in_data;
        count   <= count + ONE;
      end
`ifdef NBODY_LOADER_CLEAR_FORCES_EN
      if (hs) clr_idx <= '0;
      if (state == S_CLEAR && clr_idx != N_A) begin
        wr_en   <= 1'b1;
        wr_addr <= FB_A + clr_idx;
        wr_data <= '0;
        clr_idx <= clr_idx + ONE;
      end
`endif
    end
  end

endmodule

// File: tb/tb_nbody_body_loader.sv
// tb/tb_nbody_body_loader.sv - self-checking bench for nbody_body_loader
// Follows NBODY_LOADER_CLEAR_FORCES_EN the same way as the design.
module tb_nbody_body_loader;

  localparam int N  = 2;
  localparam int N3 = 3;
  localparam int FB = 400;
`ifdef NBODY_LOADER_CLEAR_FORCES_EN
  localparam bit CLR = 1'b1;
  localparam int OFF = 6;
`else
  localparam bit CLR = 1'b0;
  localparam int OFF = 4;
`endif

  typedef struct {
    int          cyc;
    logic [14:0] addr;
    logic [79:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [79:0] in_data;
  logic        in_ready, wr_en, busy, done;
  logic [14:0] wr_addr, count;
  logic [79:0] wr_data;

  logic        start3, in_valid3;
  logic [79:0] in_data3;
  logic        in_ready3, wr_en3, busy3, done3;
  logic [14:0] wr_addr3, count3;
  logic [79:0] wr_data3;

  int checks = 0, failures = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nbody_body_loader #(.N(N)) u_dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .count(count)
  );

  nbody_body_loader #(.N(N3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .in_valid(in_valid3), .in_data(in_data3),
    .in_ready(in_ready3), .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3),
    .busy(busy3), .done(done3), .count(count3)
  );

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: scheduled writes by absolute cycle, plus run/accept flags derived from the rules.
  wr_t         wq[$];
  wr_t         wlog[$];
  int          done_q[$];
  logic [79:0] ram[int];
  bit          m_run, m_acc;
  int          m_k, m_done_cyc;
  logic [14:0] m_last_a;
  logic [79:0] m_last_d;
  bit          e_en;
  logic [14:0] e_a;
  logic [79:0] e_d;

  always @(negedge clk) begin
    if (!reset) begin
      wq.delete();
      m_run = 0; m_acc = 0; m_k = 0; m_done_cyc = -1;
      m_last_a = '0; m_last_d = '0;
    end
    if (wq.size() > 0 && wq[0].cyc == cyc) begin
      e_en = 1; e_a = wq[0].addr; e_d = wq[0].data;
      m_last_a = e_a; m_last_d = e_d;
      void'(wq.pop_front());
    end else begin
      e_en = 0; e_a = m_last_a; e_d = m_last_d;
    end
    check($sformatf("c%0d wr_en", cyc), wr_en, e_en);
    check($sformatf("c%0d wr_addr", cyc), wr_addr, e_a);
    check($sformatf("c%0d wr_data", cyc), wr_data, e_d);
    check($sformatf("c%0d in_ready", cyc), in_ready, m_acc);
    check($sformatf("c%0d busy", cyc), busy, m_run);
    check($sformatf("c%0d done", cyc), done, cyc == m_done_cyc);
    check($sformatf("c%0d count", cyc), count, m_k);
    if (wr_en === 1'b1) begin
      wlog.push_back('{cyc, wr_addr, wr_data});
      ram[int'(wr_addr)] = wr_data;
    end
    if (done === 1'b1) done_q.push_back(cyc);
    if (reset) begin
      if (!m_run && start) begin
        m_run = 1; m_acc = 1; m_k = 0;
      end else if (m_acc && in_valid) begin
        wq.push_back('{cyc + 1, 15'(m_k), in_data});
        m_k++;
        if (m_k == N) begin
          m_acc = 0;
          if (CLR) begin
            for (int j = 0; j < N; j++) wq.push_back('{cyc + 2 + j, 15'(FB + j), 80'd0});
            m_done_cyc = cyc + 2 + N;
          end else begin
            m_done_cyc = cyc + 2;
          end
        end
      end
      if (cyc == m_done_cyc) m_run = 0;
    end
  end

  wr_t w3[$];
  int  d3[$];
  always @(negedge clk) begin
    if (wr_en3 === 1'b1) w3.push_back('{cyc, wr_addr3, wr_data3});
    if (done3 === 1'b1) d3.push_back(cyc);
  end

  // Read port of the bench RAM with 3-cycle latency.
  logic [14:0] rd_addr = '0;
  logic [79:0] p0, p1, p2;
  always @(posedge clk) begin
    p0 <= ram.exists(int'(rd_addr)) ? ram[int'(rd_addr)] : 80'hx;
    p1 <= p0;
    p2 <= p1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int n_before, output int dc);
    dc = -1;
    for (int i = 0; i < 40; i++) begin
      if (done_q.size() > n_before) break;
      tick();
    end
    if (done_q.size() > n_before) dc = done_q[n_before];
    else check("done_timeout", 0, 1);
  endtask

  task automatic readback(input logic [14:0] a, output logic [79:0] d);
    rd_addr = a;
    repeat (3) tick();
    d = p2;
  endtask

  logic [79:0] d1, d2, rd;
  wr_t         img_a[$];
  int          s, dc, nd, n1;

  initial begin
    d1 = {20{4'h1}};
    d2 = {20{4'h2}};
    reset = 0; start = 0; in_valid = 0; in_data = '0;
    start3 = 0; in_valid3 = 0; in_data3 = '0;
    repeat (3) tick();
    check("reset_wr_addr", wr_addr, 0);
    check("reset_count", count, 0);
    reset = 1;
    repeat (2) tick();

    // Back-to-back run
    wlog.delete(); nd = done_q.size(); s = cyc;
    start = 1; tick(); start = 0;
    in_valid = 1; in_data = d1; tick();
    in_data = d2; tick();
    in_valid = 0;
    wait_done(nd, dc);
    check("a_done_cycle", dc - s, OFF);
    tick();
    check("a_count", count, 2);
    check("a_nwrites", wlog.size(), CLR ? 4 : 2);
    if (wlog.size() >= 2) begin
      check("a_w0_cyc", wlog[0].cyc - s, 2);
      check("a_w0_addr", wlog[0].addr, 0);
      check("a_w0_data", wlog[0].data, d1);
      check("a_w1_addr", wlog[1].addr, 1);
      check("a_w1_data", wlog[1].data, d2);
    end
    if (CLR && wlog.size() >= 4) begin
      check("a_w2_addr", wlog[2].addr, 400);
      check("a_w3_addr", wlog[3].addr, 401);
      check("a_w3_data", wlog[3].data, 0);
      check("a_done_after_last", dc - wlog[3].cyc, 1);
    end else if (wlog.size() >= 2) begin
      check("a_done_after_last", dc - wlog[1].cyc, 1);
    end
    img_a = wlog;
    readback(15'd400, rd);
    if (CLR) check("rb_400", rd, 0);
    else check("ram400_untouched", ram.exists(400), 0);
    readback(15'd0, rd);
    check("rb_0", rd, d1);

    // Five-cycle gap between records
    wlog.delete(); nd = done_q.size(); s = cyc;
    start = 1; tick(); start = 0;
    in_valid = 1; in_data = d1; tick();
    in_valid = 0; repeat (5) tick();
    in_valid = 1; in_data = d2; tick();
    in_valid = 0;
    wait_done(nd, dc);
    check("b_done_cycle", dc - s, OFF + 5);
    check("b_nwrites", wlog.size(), img_a.size());
    for (int i = 0; i < wlog.size() && i < img_a.size(); i++) begin
      check($sformatf("b_img%0d_addr", i), wlog[i].addr, img_a[i].addr);
      check($sformatf("b_img%0d_data", i), wlog[i].data, img_a[i].data);
    end
    tick();

    // start pulses during LOAD and at the done cycle
    nd = done_q.size(); s = cyc;
    start = 1; tick();
    in_valid = 1; in_data = d2; tick();
    start = 0; in_data = d1; tick();
    in_valid = 0;
    for (int i = 0; i < 20 && cyc < s + OFF; i++) tick();
    start = 1; tick(); start = 0;
    repeat (10) tick();
    check("c_done_count", done_q.size() - nd, 1);
    check("c_busy_idle", busy, 0);

    // Reset after the first handshake
    wlog.delete(); nd = done_q.size();
    start = 1; tick(); start = 0;
    in_valid = 1; in_data = d1; tick();
    in_data = d2;
    #1 reset = 0;
    #1;
    check("d_async_wr_en", wr_en, 0);
    check("d_async_in_ready", in_ready, 0);
    check("d_async_busy", busy, 0);
    check("d_async_count", count, 0);
    check("d_async_wr_data", wr_data, 0);
    in_valid = 0;
    repeat (2) tick();
    reset = 1;
    repeat (6) tick();
    n1 = 0;
    foreach (wlog[i]) if (wlog[i].addr == 15'd1) n1++;
    check("d_addr1_writes", n1, 0);
    check("d_no_done", done_q.size() - nd, 0);

    // N=3 instance
    s = cyc;
    start3 = 1; tick(); start3 = 0;
    in_valid3 = 1;
    for (int i = 0; i < N3; i++) begin
      in_data3 = 80'h30 + 80'(i);
      tick();
    end
    in_valid3 = 0;
    repeat (15) tick();
    check("e_nwrites", w3.size(), CLR ? 6 : 3);
    for (int i = 0; i < N3 && i < w3.size(); i++) begin
      check($sformatf("e_w%0d_addr", i), w3[i].addr, i);
      check($sformatf("e_w%0d_data", i), w3[i].data, 80'h30 + 80'(i));
      check($sformatf("e_w%0d_cyc", i), w3[i].cyc - s, 2 + i);
    end
    if (CLR) for (int i = 3; i < 6 && i < w3.size(); i++)
      check($sformatf("e_w%0d_addr", i), w3[i].addr, 397 + i);
    check("e_done_count", d3.size(), 1);
    if (d3.size() > 0) check("e_done_cycle", d3[0] - s, CLR ? 8 : 5);
    check("e_count", count3, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
